// File: rtl/fadd_issue.sv
// Issue/response front end for the 2-stage fadd pipeline: operand registers, valid/tag
// shift pipe and in-order response FIFO. Optional subtract support via FADD_ISSUE_SUB_EN.
module fadd_issue #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_s,
  input  logic [31:0]      req_t,
  input  logic [TAG_W-1:0] req_tag,
`ifdef FADD_ISSUE_SUB_EN
  input  logic             req_sub,
`endif
  output logic [31:0]      add_s,
  output logic [31:0]      add_t,
  input  logic [31:0]      add_d,
  input  logic             add_overflow,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_d,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_overflow,
  output logic             busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [CW-1:0]      count;
  logic [CW-1:0]      occ;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [31:0]        mem_d   [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_o;
  logic [LATENCY-1:0] pipe_v;
  logic [TAG_W-1:0]   pipe_tag [LATENCY];
  logic               accept;
  logic               pop;
  logic               push;

  // count includes ops still in the adder, so a free slot always awaits every result
  assign req_ready     = (count < DEPTH_C);
  assign busy          = (count != '0);
  assign accept        = req_valid & req_ready;
  assign resp_valid    = (occ != '0);
  assign pop           = resp_valid & resp_ready;
  assign push          = pipe_v[LATENCY-1];
  assign resp_d        = mem_d[rd_ptr];
  assign resp_tag      = mem_tag[rd_ptr];
  assign resp_overflow = mem_o[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      add_s <= '0;
      add_t <= '0;
    end else if (accept) begin
      add_s <= req_s;
`ifdef FADD_ISSUE_SUB_EN
      add_t <= {req_t[31] ^ req_sub, req_t[30:0]};
`else
      add_t <= req_t;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v[0]   <= accept;
      pipe_tag[0] <= req_tag;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem_o  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i]   <= '0;
        mem_tag[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_d[wr_ptr]   <= add_d;
        mem_tag[wr_ptr] <= pipe_tag[LATENCY-1];
        mem_o[wr_ptr]   <= add_overflow;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ   <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: occ <= occ;
      endcase
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_issue.sv
// Self-checking bench for fadd_issue: directed scenarios plus random traffic, checked
// against a transaction-level queue model with visibility times.
module tb_fadd_issue;

  localparam int TAG_W = 6;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_s;
  logic [31:0]      req_t;
  logic [TAG_W-1:0] req_tag;
  logic             req_sub;
  logic [31:0]      add_s;
  logic [31:0]      add_t;
  logic [31:0]      add_d;
  logic             add_overflow;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_d;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_overflow;
  logic             busy;

  typedef struct {
    logic [31:0]      d;
    logic             o;
    logic [TAG_W-1:0] tag;
    int               vis;
  } ent_t;

  ent_t q[$];
  int   cyc;
  int   ncomp;
  int   nfail;

  always #5 clk = ~clk;

  fadd_issue #(.LATENCY(LAT), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_t(req_t), .req_tag(req_tag),
`ifdef FADD_ISSUE_SUB_EN
    .req_sub(req_sub),
`endif
    .add_s(add_s), .add_t(add_t), .add_d(add_d), .add_overflow(add_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_d(resp_d), .resp_tag(resp_tag), .resp_overflow(resp_overflow),
    .busy(busy)
  );

  // Stand-in adder: known IEEE cases exact, anything else an arbitrary non-commutative mix.
  function automatic logic [32:0] fm(input logic [31:0] s, input logic [31:0] t);
    if (s == 32'h3F800000 && t == 32'h40000000) return {1'b0, 32'h40400000};
    if (s == 32'h7F7FFFFF && t == 32'h7F7FFFFF) return {1'b1, 32'h7F800000};
    if (s == 32'h40400000 && t == 32'hBF800000) return {1'b0, 32'h40000000};
    return {s[31] ^ t[0], s + {t[15:0], t[31:16]}};
  endfunction

  always @(posedge clk) {add_overflow, add_d} <= fm(add_s, add_t);

  function automatic logic [31:0] eff_t(input logic [31:0] t, input logic sub);
`ifdef FADD_ISSUE_SUB_EN
    return sub ? {~t[31], t[30:0]} : t;
`else
    return (sub & 1'b0) ? t : t;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the edge, update the model.
  task automatic tick();
    logic        ev, acc, pop;
    logic [31:0] te;
    logic [32:0] r;
    ent_t        e;
    ev = (q.size() > 0) && (q[0].vis <= cyc);
    chk("req_ready", {31'b0, req_ready}, {31'b0, q.size() < DEPTH});
    chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
    if (ev) begin
      chk("resp_d", resp_d, q[0].d);
      chk("resp_tag", {26'b0, resp_tag}, {26'b0, q[0].tag});
      chk("resp_ovf", {31'b0, resp_overflow}, {31'b0, q[0].o});
    end
    acc = req_valid && (q.size() < DEPTH);
    pop = ev && resp_ready;
    te  = eff_t(req_t, req_sub);
    r   = fm(req_s, te);
    @(posedge clk);
    #1;
    cyc++;
    if (pop) void'(q.pop_front());
    if (acc) begin
      e.d = r[31:0]; e.o = r[32]; e.tag = req_tag; e.vis = cyc + LAT;
      q.push_back(e);
      chk("add_s", add_s, req_s);
      chk("add_t", add_t, te);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] s, input logic [31:0] t,
                       input logic [TAG_W-1:0] tag, input logic sub);
    req_valid = v; req_s = s; req_t = t; req_tag = tag; req_sub = sub;
  endtask

  initial begin
    ncomp = 0; nfail = 0; cyc = 0;
    rstn = 1'b0; resp_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_add_s", add_s, 32'h0);
    chk("rst_add_t", add_t, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_resp_d", resp_d, 32'h0);
    chk("rst_resp_tag", {26'b0, resp_tag}, 32'h0);
    chk("rst_resp_ovf", {31'b0, resp_overflow}, 32'h0);
    rstn = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

    // 1: single add, latency
    resp_ready = 1'b1;
    drive(1'b1, 32'h3F800000, 32'h40000000, 6'd3, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
    chk("t1_not_early", {31'b0, resp_valid}, 32'h0);
    tick();
    chk("t1_valid", {31'b0, resp_valid}, 32'h1);
    chk("t1_d", resp_d, 32'h40400000);
    chk("t1_tag", {26'b0, resp_tag}, 32'd3);
    chk("t1_ovf", {31'b0, resp_overflow}, 32'h0);
    tick();

    // 2: fill to depth with consumer stalled, then drain in order
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, $urandom, TAG_W'(10 + i), 1'b0);
      tick();
    end
    chk("t2_full_ready", {31'b0, req_ready}, 32'h0);
    chk("t2_busy", {31'b0, busy}, 32'h1);
    drive(1'b1, $urandom, $urandom, 6'd63, 1'b0);
    repeat (4) tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    resp_ready = 1'b1;
    repeat (5) tick();
    chk("t2_drained_ready", {31'b0, req_ready}, 32'h1);
    chk("t2_drained_busy", {31'b0, busy}, 32'h0);

    // 3: count=3, simultaneous accept and pop
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, TAG_W'(20 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (3) tick();
    resp_ready = 1'b1;
    drive(1'b1, $urandom, $urandom, 6'd30, 1'b0);
    tick();
    chk("t3_ready_kept", {31'b0, req_ready}, 32'h1);
    chk("t3_model_cnt", 32'(q.size()), 32'd3);
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (6) tick();

    // 4: overflow passthrough
    drive(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 6'd5, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (2) tick();
    chk("t4_d", resp_d, 32'h7F800000);
    chk("t4_ovf", {31'b0, resp_overflow}, 32'h1);
    tick();

`ifdef FADD_ISSUE_SUB_EN
    // 5: subtract flips sign of t
    drive(1'b1, 32'h40400000, 32'h3F800000, 6'd7, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (2) tick();
    chk("t5_d", resp_d, 32'h40000000);
    tick();
`endif

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, TAG_W'($urandom), 1'($urandom_range(0, 1)));
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    resp_ready = 1'b1;
    repeat (8) tick();

    // 6: reset with two ops in flight
    resp_ready = 1'b0;
    drive(1'b1, $urandom, $urandom, 6'd40, 1'b0);
    tick();
    drive(1'b1, $urandom, $urandom, 6'd41, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, resp_valid}, 32'h0);
    chk("t6_rst_busy", {31'b0, busy}, 32'h0);
    q.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    chk("t6_ready", {31'b0, req_ready}, 32'h1);
    resp_ready = 1'b1;
    repeat (6) tick();
    drive(1'b1, 32'h3F800000, 32'h40000000, 6'd9, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
